// File: rtl/alu_stream_if.sv
// Request/response bundle for alu_stream_core.
// The master drives requests and accepts results; the slave is the ALU.
interface alu_stream_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     inp_valid;
    logic           mode;
    logic [3:0]     cmd;
    logic           cin;
    logic [N-1:0]   opa;
    logic [N-1:0]   opb;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] res;
    logic           cout;
    logic           oflow;
    logic           err;
    logic           g;
    logic           l;
    logic           e;

    modport master (
        output in_valid, inp_valid, mode, cmd, cin, opa, opb, out_ready,
        input  in_ready, out_valid, res, cout, oflow, err, g, l, e
    );

    modport slave (
        input  in_valid, inp_valid, mode, cmd, cin, opa, opb, out_ready,
        output in_ready, out_valid, res, cout, oflow, err, g, l, e
    );
endinterface

// File: rtl/alu_stream_core.sv
// Handshaked parametrised ALU: single-cycle logic/arithmetic ops and an
// iterative shift-add multiplier, with a registered valid/ready result port.
module alu_stream_core #(
    parameter int N  = 8,
    parameter int RW = $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    alu_stream_if.slave bus
);
    localparam int W2 = 2 * N;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state_reg, state_next;
    logic           out_valid_reg, out_valid_next;
    logic [W2-1:0]  res_reg, res_next;
    logic           cout_reg, cout_next;
    logic           oflow_reg, oflow_next;
    logic           err_reg, err_next;
    logic           g_reg, g_next;
    logic           l_reg, l_next;
    logic           e_reg, e_next;
    logic [W2:0]    mcand_reg, mcand_next;
    logic [N-1:0]   mplier_reg, mplier_next;
    logic [W2:0]    acc_reg, acc_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           shl_reg, shl_next;

    logic [N-1:0]   a, b;
    logic [N:0]     add_ab, add_c, sub_ab, sub_c, inc_a, inc_b, sadd, ssub;
    logic [N-1:0]   dec_a, dec_b, rol_val, ror_val;
    logic [RW-1:0]  rot_amt;
    logic           rot_hi;

    // Decoded single-cycle result
    logic [W2-1:0]  op_res;
    logic [N-1:0]   lres;
    logic           op_cout, op_oflow, op_err, op_g, op_l, op_e, op_mul;
    logic           need_a, need_b, undef;

    logic           in_ready_int, accept, consume;
    logic [W2:0]    acc_step;

    assign a       = bus.opa;
    assign b       = bus.opb;
    assign add_ab  = {1'b0, a} + {1'b0, b};
    assign add_c   = add_ab + (N+1)'(bus.cin);
    assign sub_ab  = {1'b0, a} - {1'b0, b};
    assign sub_c   = sub_ab - (N+1)'(bus.cin);
    assign inc_a   = {1'b0, a} + (N+1)'(1);
    assign inc_b   = {1'b0, b} + (N+1)'(1);
    assign dec_a   = a - N'(1);
    assign dec_b   = b - N'(1);
    assign sadd    = {a[N-1], a} + {b[N-1], b};
    assign ssub    = {a[N-1], a} - {b[N-1], b};
    assign rot_amt = b[RW-1:0];
    assign rot_hi  = |b[N-1:RW];
    // A shift by N yields zero, so amount 0 degenerates cleanly to opa.
    assign rol_val = (a << rot_amt) | (a >> (N - int'(rot_amt)));
    assign ror_val = (a >> rot_amt) | (a << (N - int'(rot_amt)));

    // Operand shortage also blocks the MUL path so the error answers in one cycle.
    assign in_ready_int = !rst && ce && (state_reg == IDLE) && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && in_ready_int;
    assign consume      = out_valid_reg && bus.out_ready && ce;
    assign acc_step     = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // Decode opcode into a single-cycle result, flags and operand requirements
    always_comb begin
        op_res   = '0;
        lres     = '0;
        op_cout  = 1'b0;
        op_oflow = 1'b0;
        op_err   = 1'b0;
        op_g     = 1'b0;
        op_l     = 1'b0;
        op_e     = 1'b0;
        op_mul   = 1'b0;
        need_a   = 1'b1;
        need_b   = 1'b1;
        undef    = 1'b0;
        if (bus.mode) begin
            case (bus.cmd)
                4'd0:  begin op_res = W2'(add_ab); op_cout = add_ab[N]; end
                4'd1:  begin op_res = W2'(sub_ab[N-1:0]); op_oflow = (a < b); end
                4'd2:  begin op_res = W2'(add_c); op_cout = add_c[N]; end
                4'd3:  begin op_res = W2'(sub_c[N-1:0]); op_oflow = sub_c[N]; end
                4'd4:  begin need_b = 1'b0; op_res = W2'(inc_a); op_cout = inc_a[N]; end
                4'd5:  begin need_b = 1'b0; op_res = W2'(dec_a); op_oflow = (a == '0); end
                4'd6:  begin need_a = 1'b0; op_res = W2'(inc_b); op_cout = inc_b[N]; end
                4'd7:  begin need_a = 1'b0; op_res = W2'(dec_b); op_oflow = (b == '0); end
                4'd8:  begin op_g = (a > b); op_l = (a < b); op_e = (a == b); end
                4'd9, 4'd10: op_mul = 1'b1;
                4'd11: begin
                    op_res   = {{(N-1){sadd[N]}}, sadd};
                    op_oflow = sadd[N] ^ sadd[N-1];
                    op_g     = ($signed(a) > $signed(b));
                    op_l     = ($signed(a) < $signed(b));
                    op_e     = (a == b);
                end
                4'd12: begin
                    op_res   = {{(N-1){ssub[N]}}, ssub};
                    op_oflow = ssub[N] ^ ssub[N-1];
                    op_g     = ($signed(a) > $signed(b));
                    op_l     = ($signed(a) < $signed(b));
                    op_e     = (a == b);
                end
                default: undef = 1'b1;
            endcase
        end else begin
            case (bus.cmd)
                4'd0:  lres = a & b;
                4'd1:  lres = ~(a & b);
                4'd2:  lres = a | b;
                4'd3:  lres = ~(a | b);
                4'd4:  lres = a ^ b;
                4'd5:  lres = ~(a ^ b);
                4'd6:  begin need_b = 1'b0; lres = ~a; end
                4'd7:  begin need_a = 1'b0; lres = ~b; end
                4'd8:  begin need_b = 1'b0; lres = a >> 1; end
                4'd9:  begin need_b = 1'b0; lres = a << 1; end
                4'd10: begin need_a = 1'b0; lres = b >> 1; end
                4'd11: begin need_a = 1'b0; lres = b << 1; end
                4'd12: begin lres = rol_val; op_err = rot_hi; end
                4'd13: begin lres = ror_val; op_err = rot_hi; end
                default: undef = 1'b1;
            endcase
            op_res = {{N{1'b0}}, lres};
        end
        if (undef || (need_a && !bus.inp_valid[0]) || (need_b && !bus.inp_valid[1])) begin
            op_res   = '0;
            op_cout  = 1'b0;
            op_oflow = 1'b0;
            op_g     = 1'b0;
            op_l     = 1'b0;
            op_e     = 1'b0;
            op_mul   = 1'b0;
            op_err   = 1'b1;
        end
    end

    // Next-state, output load and multiplier step
    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        res_next       = res_reg;
        cout_next      = cout_reg;
        oflow_next     = oflow_reg;
        err_next       = err_reg;
        g_next         = g_reg;
        l_next         = l_reg;
        e_next         = e_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        acc_next       = acc_reg;
        count_next     = count_reg;
        shl_next       = shl_reg;
        if (consume) begin
            out_valid_next = 1'b0;
        end
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (op_mul) begin
                        state_next  = MUL;
                        shl_next    = (bus.cmd == 4'd10);
                        mcand_next  = (bus.cmd == 4'd10) ? (W2+1)'({a, 1'b0}) : (W2+1)'(a);
                        mplier_next = b;
                        acc_next    = '0;
                        count_next  = '0;
                    end else begin
                        out_valid_next = 1'b1;
                        res_next       = op_res;
                        cout_next      = op_cout;
                        oflow_next     = op_oflow;
                        err_next       = op_err;
                        g_next         = op_g;
                        l_next         = op_l;
                        e_next         = op_e;
                    end
                end
            end
            MUL: begin
                if (ce) begin
                    acc_next    = acc_step;
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    count_next  = count_reg + CW'(1);
                    if (count_reg == CW'(N - 1)) begin
                        state_next     = IDLE;
                        out_valid_next = 1'b1;
                        res_next       = acc_step[W2-1:0];
                        cout_next      = 1'b0;
                        oflow_next     = shl_reg && acc_step[W2];
                        err_next       = 1'b0;
                        g_next         = 1'b0;
                        l_next         = 1'b0;
                        e_next         = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; ce=0 freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            res_reg       <= '0;
            cout_reg      <= 1'b0;
            oflow_reg     <= 1'b0;
            err_reg       <= 1'b0;
            g_reg         <= 1'b0;
            l_reg         <= 1'b0;
            e_reg         <= 1'b0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            count_reg     <= '0;
            shl_reg       <= 1'b0;
        end else if (ce) begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            res_reg       <= res_next;
            cout_reg      <= cout_next;
            oflow_reg     <= oflow_next;
            err_reg       <= err_next;
            g_reg         <= g_next;
            l_reg         <= l_next;
            e_reg         <= e_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            acc_reg       <= acc_next;
            count_reg     <= count_next;
            shl_reg       <= shl_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.res       = res_reg;
    assign bus.cout      = cout_reg;
    assign bus.oflow     = oflow_reg;
    assign bus.err       = err_reg;
    assign bus.g         = g_reg;
    assign bus.l         = l_reg;
    assign bus.e         = e_reg;
endmodule

// File: tb/tb_alu_stream_core.sv
// Directed-vector bench for alu_stream_core (N=8).
// Flags are compared as {cout, oflow, err, g, l, e}.
module tb_alu_stream_core;
    logic clk = 1'b0;
    logic rst;
    logic ce;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   seen;

    alu_stream_if #(.N(8)) bus ();

    alu_stream_core #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {bus.cout, bus.oflow, bus.err, bus.g, bus.l, bus.e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] iv, input logic ci);
        bus.in_valid  = 1'b1;
        bus.mode      = m;
        bus.cmd       = c;
        bus.opa       = a;
        bus.opb       = b;
        bus.inp_valid = iv;
        bus.cin       = ci;
    endtask

    // Single-cycle op: accept on next edge, result visible right after it
    task automatic run_op(input string tag, input logic m, input logic [3:0] c,
                          input logic [7:0] a, input logic [7:0] b, input logic [1:0] iv,
                          input logic ci, input logic [15:0] exp_res, input logic [5:0] exp_flags);
        drive(m, c, a, b, iv, ci);
        step();
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".res"},   32'(bus.res), 32'(exp_res));
        check({tag, ".flags"}, 32'(flags()), 32'(exp_flags));
        $display("op %s a=%h b=%h res=%h flags=%b", tag, a, b, bus.res, flags());
    endtask

    // Multiply: accept, then N iterations; result checked after the last one
    task automatic run_mul(input string tag, input logic [3:0] c, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp_res, input logic [5:0] exp_flags);
        drive(1'b1, c, a, b, 2'b11, 1'b0);
        step();
        bus.in_valid = 1'b0;
        check({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            check({tag, ".busy"}, 32'({bus.in_ready, bus.out_valid}), 32'd0);
        end
        step();
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".res"},   32'(bus.res), 32'(exp_res));
        check({tag, ".flags"}, 32'(flags()), 32'(exp_flags));
        $display("mul %s a=%h b=%h res=%h flags=%b", tag, a, b, bus.res, flags());
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.mode      = 1'b0;
        bus.cmd       = 4'd0;
        bus.opa       = 8'h00;
        bus.opb       = 8'h00;
        bus.inp_valid = 2'b00;
        bus.cin       = 1'b0;

        // Reset state
        step();
        step();
        check("rst.valid",    32'(bus.out_valid), 32'd0);
        check("rst.res",      32'(bus.res), 32'd0);
        check("rst.flags",    32'(flags()), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("idle.in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back single-cycle ops
        run_op("add_ff_01", 1'b1, 4'd0, 8'hFF, 8'h01, 2'b11, 1'b0, 16'h0100, 6'b100000);
        check("add.in_ready", 32'(bus.in_ready), 32'd1);
        run_op("add_03_04", 1'b1, 4'd0, 8'h03, 8'h04, 2'b11, 1'b0, 16'h0007, 6'b000000);
        bus.in_valid = 1'b0;
        step();
        check("drain.valid", 32'(bus.out_valid), 32'd0);

        // Multiplies
        run_mul("mul_ff_ff", 4'd9, 8'hFF, 8'hFF, 16'hFE01, 6'b000000);
        check("mul.in_ready_after", 32'(bus.in_ready), 32'd1);
        run_mul("mulshl_80_02", 4'd10, 8'h80, 8'h02, 16'h0200, 6'b000000);
        run_mul("mulshl_ff_ff", 4'd10, 8'hFF, 8'hFF, 16'hFC02, 6'b010000);

        // Back-pressure: SUB result held while out_ready=0
        run_op("sub_05_07", 1'b1, 4'd1, 8'h05, 8'h07, 2'b11, 1'b0, 16'h00FE, 6'b010000);
        bus.out_ready = 1'b0;
        drive(1'b0, 4'd0, 8'hF0, 8'h3C, 2'b11, 1'b0);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("hold.in_ready", 32'(bus.in_ready), 32'd0);
            step();
            check("hold.valid", 32'(bus.out_valid), 32'd1);
            check("hold.res",   32'(bus.res), 32'h00FE);
            check("hold.flags", 32'(flags()), 32'b010000);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("and_on_consume.valid", 32'(bus.out_valid), 32'd1);
        check("and_on_consume.res",   32'(bus.res), 32'h0030);
        $display("op and_f0_3c res=%h", bus.res);

        // Rotates and assorted ops
        run_op("rol_81_01",  1'b0, 4'd12, 8'h81, 8'h01, 2'b11, 1'b0, 16'h0003, 6'b000000);
        run_op("rol_81_09",  1'b0, 4'd12, 8'h81, 8'h09, 2'b11, 1'b0, 16'h0003, 6'b001000);
        run_op("ror_01_00",  1'b0, 4'd13, 8'h01, 8'h00, 2'b11, 1'b0, 16'h0001, 6'b000000);
        run_op("ror_01_01",  1'b0, 4'd13, 8'h01, 8'h01, 2'b11, 1'b0, 16'h0080, 6'b000000);
        run_op("sadd_7f_01", 1'b1, 4'd11, 8'h7F, 8'h01, 2'b11, 1'b0, 16'h0080, 6'b010100);
        run_op("ssub_80_01", 1'b1, 4'd12, 8'h80, 8'h01, 2'b11, 1'b0, 16'hFF7F, 6'b010010);
        run_op("add_iv01",   1'b1, 4'd0,  8'h12, 8'h34, 2'b01, 1'b0, 16'h0000, 6'b001000);
        run_op("cmp_05_07",  1'b1, 4'd8,  8'h05, 8'h07, 2'b11, 1'b0, 16'h0000, 6'b000010);
        run_op("dec_a_00",   1'b1, 4'd5,  8'h00, 8'hAA, 2'b01, 1'b0, 16'h00FF, 6'b010000);
        run_op("inc_b_ff",   1'b1, 4'd6,  8'h55, 8'hFF, 2'b10, 1'b0, 16'h0100, 6'b100000);
        run_op("addc_ff_00", 1'b1, 4'd2,  8'hFF, 8'h00, 2'b11, 1'b1, 16'h0100, 6'b100000);
        run_op("subc_05_05", 1'b1, 4'd3,  8'h05, 8'h05, 2'b11, 1'b1, 16'h00FF, 6'b010000);
        run_op("not_a_0f",   1'b0, 4'd6,  8'h0F, 8'h00, 2'b01, 1'b0, 16'h00F0, 6'b000000);
        run_op("shl1_b_81",  1'b0, 4'd11, 8'h00, 8'h81, 2'b10, 1'b0, 16'h0002, 6'b000000);
        run_op("undef_m1_14", 1'b1, 4'd14, 8'h01, 8'h01, 2'b11, 1'b0, 16'h0000, 6'b001000);
        run_op("mul_iv10",   1'b1, 4'd9,  8'h03, 8'h03, 2'b10, 1'b0, 16'h0000, 6'b001000);
        check("mul_iv10.in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        step();

        // ce=0 pauses the multiplier; 8 enabled edges are still required
        drive(1'b1, 4'd9, 8'h03, 8'h05, 2'b11, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ce_stall.in_ready", 32'(bus.in_ready), 32'd0);
            check("ce_stall.valid",    32'(bus.out_valid), 32'd0);
        end
        ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("ce_mul.early", 32'(bus.out_valid), 32'd0);
        end
        step();
        check("ce_mul.valid", 32'(bus.out_valid), 32'd1);
        check("ce_mul.res",   32'(bus.res), 32'h000F);
        $display("mul ce_stall a=03 b=05 res=%h", bus.res);
        step();

        // Reset in the middle of a multiply aborts it
        drive(1'b1, 4'd9, 8'hFF, 8'hFF, 2'b11, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("mulrst.valid",    32'(bus.out_valid), 32'd0);
        check("mulrst.res",      32'(bus.res), 32'd0);
        check("mulrst.flags",    32'(flags()), 32'd0);
        check("mulrst.in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mulrst.in_ready_after", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("mulrst.no_stale", 32'(seen), 32'd0);
        $display("reset during mul: stale results seen=%0d", seen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
